// File: rtl/axi_read_data_router_if.sv
// AXI read-data (R) channel bundle. The master modport drives a beat, the slave modport
// accepts it. IW is the RID width carried on this particular link.
interface axi_read_data_router_if #(
  parameter int unsigned IW = 4,
  parameter int unsigned DW = 32
);
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  modport master (output rid, rdata, rresp, rlast, rvalid, input rready);
  modport slave  (input rid, rdata, rresp, rlast, rvalid, output rready);
endinterface

// File: rtl/axi_read_data_router.sv
// Round-robin R-channel return router: S0/S1/SD bursts are locked per RLAST and steered to
// M0/M1 by the RID tag. Define RD_SKID_BUF_EN for a 2-entry registered skid FIFO on the output.
module axi_read_data_router #(
  parameter int unsigned IDW = 4,
  parameter int unsigned DW  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_read_data_router_if.slave  s0,
  axi_read_data_router_if.slave  s1,
  axi_read_data_router_if.slave  sd,
  axi_read_data_router_if.master m0,
  axi_read_data_router_if.master m1
);
  localparam int unsigned SIW = IDW + 4;
  localparam logic [1:0] GrantNone = 2'd3;
  localparam logic [1:0] SlvSd     = 2'd2;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;

  logic [SIW-1:0] s_rid   [3];
  logic [DW-1:0]  s_rdata [3];
  logic [1:0]     s_rresp [3];
  logic [2:0]     s_rlast, s_rvalid, s_rready;
  logic [1:0]     m_rready;

  assign s_rid[0]   = s0.rid;
  assign s_rid[1]   = s1.rid;
  assign s_rid[2]   = sd.rid;
  assign s_rdata[0] = s0.rdata;
  assign s_rdata[1] = s1.rdata;
  assign s_rdata[2] = sd.rdata;
  assign s_rresp[0] = s0.rresp;
  assign s_rresp[1] = s1.rresp;
  assign s_rresp[2] = sd.rresp;
  assign s_rlast    = {sd.rlast, s1.rlast, s0.rlast};
  assign s_rvalid   = {sd.rvalid, s1.rvalid, s0.rvalid};
  assign s0.rready  = s_rready[0];
  assign s1.rready  = s_rready[1];
  assign sd.rready  = s_rready[2];
  assign m_rready   = {m1.rready, m0.rready};

  logic [SIW-1:0] g_rid;
  logic [DW-1:0]  g_rdata;
  logic [1:0]     g_rresp;
  logic           g_rlast, g_rvalid, g_ready;
  logic [3:0]     g_tag;
  logic           g_dest, g_discard, burst;

  always_comb begin
    g_rid    = '0;
    g_rdata  = '0;
    g_rresp  = '0;
    g_rlast  = 1'b0;
    g_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q == 2'(i)) begin
        g_rid    = s_rid[i];
        g_rdata  = s_rdata[i];
        g_rresp  = s_rresp[i];
        g_rlast  = s_rlast[i];
        g_rvalid = s_rvalid[i];
      end
    end
  end

  assign burst     = (state_q == StBurst);
  assign g_tag     = g_rid[SIW-1:IDW];
  assign g_dest    = g_tag[0];
  // Tags other than 0/1 are swallowed so a misrouted slave cannot stall the shared path.
  assign g_discard = |g_tag[3:1];

  always_comb begin
    s_rready = '0;
    for (int i = 0; i < 3; i++) begin
      s_rready[i] = burst && (grant_q == 2'(i)) && g_ready;
    end
  end

  logic [2:0] cand;
  logic       found;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cand     = '0;
    found    = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int i = 0; i < 3; i++) begin
          cand = {1'b0, rr_ptr_q} + 3'(i);
          if (cand >= 3'd3) cand = cand - 3'd3;
          if (!found && s_rvalid[cand[1:0]]) begin
            found   = 1'b1;
            grant_d = cand[1:0];
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        if (g_rvalid && g_ready && g_rlast) begin
          state_d  = StIdle;
          grant_d  = GrantNone;
          rr_ptr_d = (grant_q == SlvSd) ? 2'd0 : grant_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      grant_q  <= GrantNone;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef RD_SKID_BUF_EN
  typedef struct packed {
    logic           dest;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
  } beat_t;

  beat_t      fifo_q [2];
  beat_t      head, in_beat;
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q;
  logic       full, push, pop;

  assign full    = (cnt_q == 2'd2);
  assign head    = fifo_q[rd_ptr_q];
  assign in_beat = {g_dest, g_rid[IDW-1:0], g_rdata, g_rresp, g_rlast};
  assign g_ready = g_discard || !full;
  assign push    = burst && g_rvalid && !g_discard && !full;
  assign pop     = (cnt_q != 2'd0) && m_rready[head.dest];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= in_beat;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_comb begin
    m0.rid = '0; m0.rdata = '0; m0.rresp = '0; m0.rlast = 1'b0; m0.rvalid = 1'b0;
    m1.rid = '0; m1.rdata = '0; m1.rresp = '0; m1.rlast = 1'b0; m1.rvalid = 1'b0;
    if (cnt_q != 2'd0) begin
      if (head.dest) begin
        m1.rid = head.rid; m1.rdata = head.rdata; m1.rresp = head.rresp;
        m1.rlast = head.rlast; m1.rvalid = 1'b1;
      end else begin
        m0.rid = head.rid; m0.rdata = head.rdata; m0.rresp = head.rresp;
        m0.rlast = head.rlast; m0.rvalid = 1'b1;
      end
    end
  end
`else
  always_comb begin
    m0.rid = '0; m0.rdata = '0; m0.rresp = '0; m0.rlast = 1'b0; m0.rvalid = 1'b0;
    m1.rid = '0; m1.rdata = '0; m1.rresp = '0; m1.rlast = 1'b0; m1.rvalid = 1'b0;
    g_ready = 1'b0;
    if (burst) begin
      g_ready = g_discard ? 1'b1 : m_rready[g_dest];
      if (g_rvalid && !g_discard) begin
        if (g_dest) begin
          m1.rid = g_rid[IDW-1:0]; m1.rdata = g_rdata; m1.rresp = g_rresp;
          m1.rlast = g_rlast; m1.rvalid = 1'b1;
        end else begin
          m0.rid = g_rid[IDW-1:0]; m0.rdata = g_rdata; m0.rresp = g_rresp;
          m0.rlast = g_rlast; m0.rvalid = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_data_router.sv
// Scoreboard bench for axi_read_data_router: slave beats are queued per master when accepted
// and matched against master-side handshakes; arbitration order is tracked separately.
module tb_axi_read_data_router;
  localparam int unsigned IDW = 4;
  localparam int unsigned DW  = 32;
  localparam int Timeout = 50;
`ifdef RD_SKID_BUF_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_read_data_router_if #(.IW(IDW + 4), .DW(DW)) s0_if ();
  axi_read_data_router_if #(.IW(IDW + 4), .DW(DW)) s1_if ();
  axi_read_data_router_if #(.IW(IDW + 4), .DW(DW)) sd_if ();
  axi_read_data_router_if #(.IW(IDW), .DW(DW)) m0_if ();
  axi_read_data_router_if #(.IW(IDW), .DW(DW)) m1_if ();

  axi_read_data_router #(.IDW(IDW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .s0  (s0_if),
    .s1  (s1_if),
    .sd  (sd_if),
    .m0  (m0_if),
    .m1  (m1_if)
  );

  logic [IDW+3:0] s_rid_r   [3];
  logic [DW-1:0]  s_rdata_r [3];
  logic [1:0]     s_rresp_r [3];
  logic           s_rlast_r [3];
  logic           s_rvalid_r[3];
  logic           s_rready_w[3];
  logic           m_rready_r[2];
  logic           m_rvalid_w[2];
  exp_t           m_beat_w  [2];

  assign s0_if.rid = s_rid_r[0];   assign s0_if.rdata = s_rdata_r[0];
  assign s0_if.rresp = s_rresp_r[0]; assign s0_if.rlast = s_rlast_r[0];
  assign s0_if.rvalid = s_rvalid_r[0];
  assign s1_if.rid = s_rid_r[1];   assign s1_if.rdata = s_rdata_r[1];
  assign s1_if.rresp = s_rresp_r[1]; assign s1_if.rlast = s_rlast_r[1];
  assign s1_if.rvalid = s_rvalid_r[1];
  assign sd_if.rid = s_rid_r[2];   assign sd_if.rdata = s_rdata_r[2];
  assign sd_if.rresp = s_rresp_r[2]; assign sd_if.rlast = s_rlast_r[2];
  assign sd_if.rvalid = s_rvalid_r[2];
  assign s_rready_w[0] = s0_if.rready;
  assign s_rready_w[1] = s1_if.rready;
  assign s_rready_w[2] = sd_if.rready;
  assign m0_if.rready = m_rready_r[0];
  assign m1_if.rready = m_rready_r[1];
  assign m_rvalid_w[0] = m0_if.rvalid;
  assign m_rvalid_w[1] = m1_if.rvalid;
  assign m_beat_w[0] = {m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast};
  assign m_beat_w[1] = {m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast};

  int   n_checks = 0;
  int   n_pass = 0;
  int   cycle = 0;
  int   acc_order[$];
  int   acc_cycle[$];
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   vcnt[2];
  int   stall_seen = 0;
  bit   ok_a, ok_b;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: sample at negedge, retire the handshake at the following posedge.
  logic mon_f [2];
  exp_t mon_got [2];
  exp_t hold [2];
  logic hold_v [2];
  exp_t want;
  initial begin
    hold_v[0] = 1'b0;
    hold_v[1] = 1'b0;
    vcnt[0] = 0;
    vcnt[1] = 0;
  end

  always begin
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      mon_f[m]   = rst && m_rvalid_w[m] && m_rready_r[m];
      mon_got[m] = m_beat_w[m];
      if (m_rvalid_w[m]) vcnt[m]++;
      if (hold_v[m] && rst) begin
        n_checks++;
        if (m_rvalid_w[m] === 1'b1 && mon_got[m] === hold[m]) n_pass++;
        else $display("FAIL stall_hold_m%0d: got v=%b %h, want v=1 %h", m, m_rvalid_w[m],
                      mon_got[m], hold[m]);
      end
      hold_v[m] = rst && m_rvalid_w[m] && !m_rready_r[m];
      hold[m]   = mon_got[m];
      if (hold_v[m]) stall_seen++;
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (mon_f[m]) begin
        n_checks++;
        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
          $display("FAIL beat_m%0d: got unexpected beat %h, want none", m, mon_got[m]);
        end else begin
          if (m == 0) want = exp_q0.pop_front();
          else want = exp_q1.pop_front();
          if (mon_got[m] === want) n_pass++;
          else $display("FAIL beat_m%0d: got %h, want %h", m, mon_got[m], want);
        end
      end
    end
  end

  // Presents n_send beats of an n_total burst; if n_send < n_total the next beat stays presented.
  task automatic send_burst(input int s, input logic [7:0] rid, input logic [DW-1:0] base,
                            input int n_send, input int n_total, output bit ok);
    bit   got;
    exp_t e;
    ok = 1'b1;
    for (int k = 0; k < n_send && ok; k++) begin
      got = 1'b0;
      s_rid_r[s] = rid; s_rdata_r[s] = base + DW'(k); s_rresp_r[s] = 2'(k);
      s_rlast_r[s] = (k == n_total - 1); s_rvalid_r[s] = 1'b1;
      for (int c = 0; c < Timeout && !got; c++) begin
        @(negedge clk);
        if (s_rready_w[s]) begin
          got = 1'b1;
          acc_order.push_back(s);
          acc_cycle.push_back(cycle);
          e = {rid[3:0], base + DW'(k), 2'(k), (k == n_total - 1)};
          if (rid[7:4] == 4'd0) exp_q0.push_back(e);
          else if (rid[7:4] == 4'd1) exp_q1.push_back(e);
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (got) n_pass++;
      else begin
        $display("FAIL accept_s%0d_beat%0d: got no handshake in %0d cycles, want handshake",
                 s, k, Timeout);
        ok = 1'b0;
      end
    end
    if (ok && n_send < n_total) begin
      s_rdata_r[s] = base + DW'(n_send); s_rresp_r[s] = 2'(n_send);
      s_rlast_r[s] = (n_send == n_total - 1);
    end else begin
      s_rvalid_r[s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      s_rid_r[s] = '0; s_rdata_r[s] = '0; s_rresp_r[s] = '0; s_rlast_r[s] = 1'b0;
      s_rvalid_r[s] = 1'b0;
    end
    m_rready_r[0] = 1'b1; m_rready_r[1] = 1'b1;
    s_rid_r[0] = 8'h01; s_rdata_r[0] = 32'hdead; s_rlast_r[0] = 1'b1; s_rvalid_r[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_rvalid_w[0], m_rvalid_w[1], m_beat_w[0], m_beat_w[1]} === '0) n_pass++;
    else $display("FAIL reset_outputs: got %h %h, want all 0", m_beat_w[0], m_beat_w[1]);
    n_checks++;
    if ({s_rready_w[0], s_rready_w[1], s_rready_w[2]} === 3'b000) n_pass++;
    else $display("FAIL reset_rready: got %b%b%b, want 000", s_rready_w[0], s_rready_w[1],
                  s_rready_w[2]);
    @(posedge clk); #1;
    s_rvalid_r[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    s_rvalid_r[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_rready_w[0] === 1'b0 && m_rvalid_w[0] === 1'b0) n_pass++;
    else $display("FAIL idle_no_forward: got rready=%b m0_rvalid=%b, want 0 0", s_rready_w[0],
                  m_rvalid_w[0]);
    #1 s_rvalid_r[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    acc_order.delete(); acc_cycle.delete();
    fork
      send_burst(0, 8'h01, 32'h100, 1, 1, ok_a);
      send_burst(1, 8'h12, 32'h200, 1, 1, ok_b);
      send_burst(2, 8'h03, 32'h300, 1, 1, ok_a);
    join
    n_checks++;
    if (acc_order.size() == 3 && acc_order[0] == 0 && acc_order[1] == 1 && acc_order[2] == 2)
      n_pass++;
    else $display("FAIL rr_order: got %p, want 0 1 2", acc_order);
    n_checks++;
    if (acc_cycle.size() == 3 && acc_cycle[1] - acc_cycle[0] == 2 &&
        acc_cycle[2] - acc_cycle[1] == 2) n_pass++;
    else $display("FAIL rr_bubble: got cycles %p, want spacing 2", acc_cycle);
    // Pointer must be back at S0: S0 beats SD when both request.
    acc_order.delete();
    fork
      send_burst(2, 8'h05, 32'h350, 1, 1, ok_a);
      send_burst(0, 8'h04, 32'h150, 1, 1, ok_b);
    join
    n_checks++;
    if (acc_order.size() == 2 && acc_order[0] == 0 && acc_order[1] == 2) n_pass++;
    else $display("FAIL rr_wrap: got %p, want 0 2", acc_order);
  endtask

  task automatic test_s1_burst();
    int n;
    bit seen;
    vcnt[0] = 0;
    n = 0; seen = 1'b0;
    fork
      send_burst(1, 8'h13, 32'hA0, 4, 4, ok_a);
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (m_rvalid_w[1]) seen = 1'b1;
        else n++;
      end
    join
    n_checks++;
    if (seen && n == Lat) n_pass++;
    else $display("FAIL s1_latency: got %0d cycles, want %0d", n, Lat);
    n_checks++;
    if (vcnt[0] == 0) n_pass++;
    else $display("FAIL s1_m0_quiet: got %0d m0 valid cycles, want 0", vcnt[0]);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    send_burst(0, 8'h02, 32'h400, 1, 4, ok_a);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({m_rvalid_w[0], m_rvalid_w[1], m_beat_w[0], m_beat_w[1]} === '0) n_pass++;
    else $display("FAIL midrst_outputs: got %h %h, want all 0", m_beat_w[0], m_beat_w[1]);
    n_checks++;
    if (s_rready_w[0] === 1'b0) n_pass++;
    else $display("FAIL midrst_rready: got %b, want 0", s_rready_w[0]);
    s_rvalid_r[0] = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    acc_order.delete();
    fork
      send_burst(2, 8'h17, 32'h480, 1, 1, ok_a);
      send_burst(0, 8'h06, 32'h440, 1, 1, ok_b);
    join
    n_checks++;
    if (acc_order.size() == 2 && acc_order[0] == 0 && acc_order[1] == 2) n_pass++;
    else $display("FAIL midrst_rearb: got %p, want 0 2", acc_order);
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    pat = 4'b1001;
    stall_seen = 0;
    acc_order.delete();
    fork
      send_burst(0, 8'h07, 32'h700, 3, 3, ok_a);
      send_burst(2, 8'h16, 32'h800, 1, 1, ok_b);
      begin
        for (int c = 0; c < 16; c++) begin
          m_rready_r[0] = pat[c % 4];
          @(posedge clk); #1;
        end
        m_rready_r[0] = 1'b1;
      end
    join
    n_checks++;
    if (acc_order.size() == 4 && acc_order[0] == 0 && acc_order[1] == 0 && acc_order[2] == 0 &&
        acc_order[3] == 2) n_pass++;
    else $display("FAIL stall_lock: got %p, want 0 0 0 2", acc_order);
    n_checks++;
    if (stall_seen > 0) n_pass++;
    else $display("FAIL stall_seen: got %0d stalled cycles, want >0", stall_seen);
  endtask

  task automatic test_discard();
    m_rready_r[0] = 1'b0; m_rready_r[1] = 1'b0;
    vcnt[0] = 0; vcnt[1] = 0;
    send_burst(2, 8'h53, 32'h900, 2, 2, ok_a);
    n_checks++;
    if (ok_a && vcnt[0] == 0 && vcnt[1] == 0) n_pass++;
    else $display("FAIL discard: got done=%b m0v=%0d m1v=%0d, want 1 0 0", ok_a, vcnt[0],
                  vcnt[1]);
    m_rready_r[0] = 1'b1; m_rready_r[1] = 1'b1;
  endtask

`ifdef RD_SKID_BUF_EN
  task automatic test_skid();
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    m_rready_r[0] = 1'b0;
    acc_order.delete();
    fork
      send_burst(0, 8'h09, 32'hB00, 8, 8, ok_a);
      begin
        repeat (4) @(negedge clk);
        n_checks++;
        if (s_rready_w[0] === 1'b0 && acc_order.size() == 2) n_pass++;
        else $display("FAIL skid_full: got rready=%b buffered=%0d, want 0 2", s_rready_w[0],
                      acc_order.size());
        @(posedge clk); #1;
        m_rready_r[0] = 1'b1;
      end
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (m_rvalid_w[0]) seen = 1'b1;
        else n++;
      end
    join
    n_checks++;
    if (seen && n == 2) n_pass++;
    else $display("FAIL skid_latency: got %0d cycles, want 2", n);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_s1_burst();
    test_mid_reset();
    test_stall();
    test_discard();
`ifdef RD_SKID_BUF_EN
    test_skid();
`endif
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q0.size() == 0 && exp_q1.size() == 0) n_pass++;
    else $display("FAIL drained: got %0d/%0d beats outstanding, want 0/0", exp_q0.size(),
                  exp_q1.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_read_data_router.md
# axi_read_data_router

- Routes the AXI read-data (R) channel from the three slave ports (S0, S1, default slave SD) back to the two master ports (M0, M1).
- It is the return-path counterpart of the interconnect's write-data steering:
  - Slaves compete for one shared R path through a round-robin arbiter.
  - Each burst is locked to its slave until the RLAST handshake.
  - Each beat is steered to the master encoded in the upper RID bits.
- Sits in the AXI interconnect between the slave-side R channels and the master-side R channels.

## Interface
Parameters:
- IDW, 4, master-side ID width
- DW, 32, data width

Ports (x ∈ {S0,S1,SD}, m ∈ {M0,M1}):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- x_RID  in  IDW+4  [IDW+3:IDW] = master tag, [IDW-1:0] = original ID
- x_RDATA  in  DW  read data
- x_RRESP  in  2  response
- x_RLAST  in  1  last beat
- x_RVALID  in  1  beat valid
- x_RREADY  out  1  beat accepted
- m_RID  out  IDW  original ID, tag stripped
- m_RDATA  out  DW  read data
- m_RRESP  out  2  response
- m_RLAST  out  1  last beat
- m_RVALID  out  1  beat valid
- m_RREADY  in  1  master ready

## Operation
- State machine: IDLE, BURST. Reset values:
  - state = IDLE
  - grant = none
  - rr_ptr = S0
  - all outputs 0
- IDLE:
  - Search order starts at rr_ptr and wraps S0→S1→SD→S0.
  - First slave with RVALID=1 is registered into grant; state → BURST.
  - No beat is forwarded in IDLE; all x_RREADY = 0.
- BURST, forwarding:
  - Only the granted slave is forwarded; every non-granted x_RREADY = 0.
  - Destination is taken from the granted x_RID tag:
    - tag 0 → M0.
    - tag 1 → M1.
    - Any other tag → discard: granted x_RREADY = 1 and no m_RVALID, so the slave cannot hang.
  - Selected master: m_RVALID = x_RVALID; m_RID = x_RID[IDW-1:0]; m_RDATA, m_RRESP and m_RLAST are copied from the granted slave.
  - granted x_RREADY = m_RREADY of the selected master.
  - The non-selected master has all outputs at 0.
- BURST, termination:
  - Burst ends on slave-side handshake (x_RVALID & x_RREADY & x_RLAST): state → IDLE, grant cleared, rr_ptr = granted+1 (SD wraps to S0).
  - If the granted x_RVALID drops mid-burst, stay in BURST; no other slave is granted.
- Tag is re-evaluated each beat (combinational on x_RID); slaves must hold RID constant within a burst.
- Unused m_RDATA, m_RID and m_RRESP are driven 0 when m_RVALID = 0.

## Timing
- Arbitration costs 1 cycle: a beat presented in IDLE at cycle t is first visible on m_* at t+1 (RD_SKID_BUF_EN off).
- Throughput is 1 beat/cycle within a burst, with a 1-cycle IDLE bubble between bursts.
- Handshake: a beat transfers on the rising clk where m_RVALID & m_RREADY.
- Simultaneous requests in IDLE: rr_ptr decides. Requests arriving during BURST wait for IDLE.
- Single-beat burst (RLAST on first beat): BURST lasts 1 cycle if m_RREADY = 1.
- Reset asserted mid-burst: immediately IDLE, grant cleared, rr_ptr = S0, all outputs 0, any buffered beat lost.

## Configuration
- RD_SKID_BUF_EN defined:
  - A 2-entry FIFO holding {dest, RID, RDATA, RRESP, RLAST} sits between the arbiter and the masters.
  - x_RREADY = granted & FIFO not full (discard tags bypass the FIFO).
  - Master outputs come from the FIFO head, registered.
  - Adds 1 cycle latency (first beat at t+2); throughput is still 1 beat/cycle.
  - The burst ends on the slave-side RLAST handshake, so the next arbitration may overlap draining.
  - FIFO is empty after reset.
- Undefined: the combinational forwarding described above, with no storage.

## Test plan
- S1 sends a 4-beat burst, RID = 8'h13, data 0xA0–A3, M1_RREADY = 1:
  - M1 sees RID 4'h3, data A0–A3, RLAST on beat 4, first beat at cycle t+1.
  - M0_RVALID stays 0 throughout.
- S0, S1 and SD all assert RVALID in the same cycle after reset, each with a single-beat burst:
  - Grants occur in order S0, S1, SD, with a 1-cycle bubble between them.
  - rr_ptr returns to S0.
- S0 burst to M0 with M0_RREADY toggling 1,0,0,1 while SD requests:
  - Each beat is held stable while stalled.
  - SD is not granted until S0's RLAST handshake.
- SD beat with tag 4'h5:
  - SD_RREADY = 1, both m_RVALID = 0, and the burst completes on RLAST.
- rst pulsed low mid-burst on beat 2 of 4:
  - All outputs 0 within the reset window; state = IDLE.
  - Re-arbitration after release starts at S0.
- With RD_SKID_BUF_EN defined, 8-beat burst with M0_RREADY held 0 for 3 cycles:
  - S0_RREADY drops after 2 beats are buffered.
  - No beat lost or duplicated; first-beat latency is 2 cycles.
